// File: rtl/lstm_pkg.sv
// Shared LSTM fixed-point definitions: data width, fraction position, signed data type and saturating add.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package lstm_pkg;

    localparam int DEF_BIT_WIDTH = 18;
    localparam int FRAC_BITS     = 10;

    typedef logic signed [DEF_BIT_WIDTH-1:0] data_t;

    // Result of sat_add: sum already clamped to the requested width, plus overflow flag.
    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sat_res_t;

    // Adds two values that each fit in 'width' signed bits (sign-extended to 64).
    // Overflow is detected by comparing the operand signs with the sum sign at
    // bit width-1; on overflow the sum clamps to the width's min or max.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 width);
        sat_res_t           r;
        logic signed [63:0] raw;
        logic signed [63:0] lim;
        raw   = a + b;
        lim   = 64'sd1 <<< (width - 1);
        r.ovf = (a[width-1] == b[width-1]) && (raw[width-1] != a[width-1]);
        if (r.ovf) begin
            r.sum = a[width-1] ? -lim : (lim - 64'sd1);
        end else begin
            r.sum = raw;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_accumulator.sv
// Sums a framed stream of signed products into one saturated dot-product term per vector.
// Latency: result valid the cycle after the last beat is accepted; one result per two cycles at best.
// Backpressure: in_ready drops while a result is held; held result stays stable until out_ready.
module dot_accumulator
    import lstm_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int GUARD_BITS = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    localparam int ACC_W = BIT_WIDTH + GUARD_BITS;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]           state_q,   state_d;
    logic [ACC_W-1:0]     acc_q,     acc_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic                 flag_q,    flag_d;
    logic                 out_vld_q, out_vld_d;
    logic [BIT_WIDTH-1:0] out_dat_q, out_dat_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                 out_sat_q, out_sat_d;

    sat_res_t             add_res;
    logic [ACC_W-1:0]     add_sum;
    logic                 add_ovf;
    logic                 clip;
    logic [BIT_WIDTH-1:0] clip_val;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // Only the state register drives in_ready, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_count = out_cnt_q;
    assign out_sat   = out_sat_q;

    // Guarded add of the incoming term, then clip of that sum to the output width.
    always_comb begin
        add_res  = sat_add({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                           {{(64-BIT_WIDTH){in_data[BIT_WIDTH-1]}}, in_data},
                           ACC_W);
        add_sum  = add_res.sum[ACC_W-1:0];
        add_ovf  = add_res.ovf;
        // Value fits in BIT_WIDTH only if every bit from BIT_WIDTH-1 upward equals the sign.
        clip     = !(&add_sum[ACC_W-1:BIT_WIDTH-1]) && (|add_sum[ACC_W-1:BIT_WIDTH-1]);
        clip_val = clip ? {add_sum[ACC_W-1], {(BIT_WIDTH-1){~add_sum[ACC_W-1]}}}
                        : add_sum[BIT_WIDTH-1:0];
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state: accumulate beats in ACCUM, publish and clear on the last beat, release in HOLD.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_cnt_d = out_cnt_q;
        out_sat_d = out_sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    if (!in_last) begin
                        acc_d  = add_sum;
                        cnt_d  = cnt_inc;
                        flag_d = flag_q | add_ovf;
                    end else begin
                        out_dat_d = clip_val;
                        out_sat_d = clip | flag_q | add_ovf;
                        out_cnt_d = cnt_inc;
                        out_vld_d = 1'b1;
                        state_d   = ST_HOLD;
                        acc_d     = '0;
                        cnt_d     = '0;
                        flag_d    = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_ACCUM;
                end
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sum or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_cnt_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_cnt_q <= out_cnt_d;
            out_sat_q <= out_sat_d;
        end
    end

endmodule
